data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//   MIPS data memory: word-addressed RAM of WORD_SIZE words, WORD_SIZE bits each.
//   Provides a synchronous write port and an asynchronous (combinational) read on one shared byte address.
//   Sits in the MEM stage; the address comes from the ALU result, the write data from register rt.
//   A load reads data_ram; a store writes when signal_we is asserted.
// PARAMETERS
//   WORD_SIZE  32                  data width in bits, and also the memory depth in words
//   ADDRES     $clog2(WORD_SIZE)   index width; 5 for the default
// PORTS
//   clk           in   1          rising-edge clock
//   rst_n         in   1          asynchronous, active-low reset
//   signal_we     in   1          write enable; active high, sampled on rising clk
//   addres_write  in   WORD_SIZE  byte address shared by read and write
//   data_write    in   WORD_SIZE  write data
//   data_ram      out  WORD_SIZE  read data at the current addres_write
// BEHAVIOUR
//   - Storage: array RAM[0:WORD_SIZE-1] of WORD_SIZE-bit words.
//     Named RAM so that benches can read it hierarchically.
//   - Index: idx = addres_write[ADDRES+1:2], which is word addressing.
//     Byte-offset bits [1:0] are ignored; unaligned addresses round down to the word.
//     Bits above ADDRES+1 are ignored, so addresses alias modulo WORD_SIZE*4 bytes.
//   - Reset: when rst_n=0, all RAM words clear to 0 asynchronously and immediately.
//     Consequently data_ram=0 during and right after reset.
//     Writes are blocked while rst_n=0.
//     If reset is asserted mid-operation, it overrides any pending write in that cycle.
//   - Write: at posedge clk with rst_n=1 and signal_we=1, RAM[idx] <= data_write.
//     Exactly one word is written. There are no byte enables.
//   - signal_we=0, or X/Z treated as not-1: RAM is unchanged.
//   - Read: data_ram = RAM[idx], combinational, with zero latency; it follows addres_write within the cycle.
//   - Read during write to the same idx: before the edge, data_ram shows the old value.
//     After the edge, it shows the new value. No bypass.
//   - Back-to-back writes: one per cycle with no stall; the last write to an idx wins.
//   - No handshake and no error outputs. Write latency is 1 cycle; read latency is 0.
// TESTING
//   1. Assert rst_n=0, then release -> every RAM[i]=0 and data_ram=0 for any address.
//   2. Write one word per consecutive cycle with we=1:
//      0x0<-0x1, 0x4<-0x10, 0x8<-0x100, 0xC<-0x1000.
//      Then 2 idle cycles -> RAM[0..3]=1,0x10,0x100,0x1000; all other words 0.
//   3. Set we=0, addr=0x8, data_write=0xDEADBEEF, apply an edge
//      -> RAM[2] stays 0x100; data_ram=0x100 combinationally.
//   4. Write addr=0x6 (unaligned) <- 0xA5 -> RAM[1]=0xA5.
//      Write addr=0x80 <- 0x77 -> aliases to RAM[0]=0x77.
//   5. Drive addr=0x4 with we=1, data=0x55 -> data_ram shows the old RAM[1] before the edge and 0x55 after.
//   6. Assert rst_n low between clock edges after writes -> RAM clears immediately without an edge.
//      A write attempted while in reset has no effect.

Source files
------------

// File: rtl/data_memory.sv
// Data memory for the MEM stage of a MIPS pipeline.
// The memory holds WORD_SIZE words of WORD_SIZE bits each and is addressed by word.
// A write is synchronous and takes one clock edge.
// A read is combinational, so data_ram follows addres_write within the same cycle.
// Reads and writes share one byte address. Byte-offset bits [1:0] are dropped.
// Address bits above the index field are also dropped, so addresses alias modulo WORD_SIZE*4 bytes.
module data_memory #(
  parameter int WORD_SIZE = 32,
  parameter int ADDRES    = $clog2(WORD_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 signal_we,
  input  logic [WORD_SIZE-1:0] addres_write,
  input  logic [WORD_SIZE-1:0] data_write,
  output logic [WORD_SIZE-1:0] data_ram
);

  // The name RAM is kept so that benches can reach the storage hierarchically.
  logic [WORD_SIZE-1:0] RAM [0:WORD_SIZE-1];

  // Word index taken from the byte address.
  logic [ADDRES-1:0] idx;

  // The byte-offset bits and the aliased upper bits play no part in addressing.
  logic unused_addr_bits;

  assign idx = addres_write[ADDRES+1:2];
  assign unused_addr_bits = ^{addres_write[WORD_SIZE-1:ADDRES+2], addres_write[1:0]};

  // Storage update: the asynchronous clear has priority over a write on the same edge.
  // NOTE: the whole array sits under the async reset because a load issued right
  //       after reset must return 0, not leftover contents.
  //       This rules out mapping the array onto a block RAM, which is acceptable at this depth.
  //       Non-blocking assignments keep same-edge readers seeing the pre-edge value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORD_SIZE; i++) begin
        RAM[i] <= '0;
      end
    end else if (signal_we) begin
      RAM[idx] <= data_write;
    end
  end

  // Combinational read. During a write cycle it shows the old word until the edge; there is no bypass.
  always_comb begin
    data_ram = RAM[idx];
  end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory.
// A reference array is indexed by (byte_address / 4) mod 32.
// It is updated only on a clock edge where reset is released and the write enable is 1,
// and it is cleared whenever reset is asserted.
module tb_data_memory;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         signal_we;
  logic [W-1:0] addres_write;
  logic [W-1:0] data_write;
  logic [W-1:0] data_ram;

  logic [W-1:0] model [W];
  int total;
  int bad;

  data_memory #(.WORD_SIZE(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .signal_we    (signal_we),
    .addres_write (addres_write),
    .data_write   (data_write),
    .data_ram     (data_ram)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int word_of(input logic [W-1:0] a);
    return int'((a / 4) % W);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s_ram%0d", tag, i), dut.RAM[i], model[i]);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < W; i++) model[i] = '0;
  endtask

  // Drive one cycle. Expect the old word before the edge and the model value after it.
  task automatic apply(input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                       input string tag);
    signal_we    = we;
    addres_write = a;
    data_write   = d;
    #1;
    check({tag, "_pre"}, data_ram, model[word_of(a)]);
    @(posedge clk);
    if (we === 1'b1 && rst_n === 1'b1) model[word_of(a)] = d;
    #1;
    check({tag, "_post"}, data_ram, model[word_of(a)]);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clear_model();
    rst_n        = 1'b1;
    signal_we    = 1'b0;
    addres_write = '0;
    data_write   = '0;

    // Reset: every word reads 0 during reset and after release.
    #3 rst_n = 1'b0;
    #1;
    check_all("rst_in");
    check("rst_in_read", data_ram, 32'h0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_out");
    addres_write = 32'h0000_007C;
    #1;
    check("rst_out_read_7c", data_ram, 32'h0);

    // Back-to-back writes, one per cycle, followed by two idle cycles.
    apply(1'b1, 32'h0, 32'h1,    "wr0");
    apply(1'b1, 32'h4, 32'h10,   "wr1");
    apply(1'b1, 32'h8, 32'h100,  "wr2");
    apply(1'b1, 32'hC, 32'h1000, "wr3");
    apply(1'b0, 32'h0, 32'h0,    "idle0");
    apply(1'b0, 32'h0, 32'h0,    "idle1");
    check("seq_ram0", dut.RAM[0], 32'h1);
    check("seq_ram1", dut.RAM[1], 32'h10);
    check("seq_ram2", dut.RAM[2], 32'h100);
    check("seq_ram3", dut.RAM[3], 32'h1000);
    check_all("seq");

    // With write enable low, an edge leaves RAM unchanged.
    apply(1'b0, 32'h8, 32'hDEAD_BEEF, "we0");
    check("we0_ram2", dut.RAM[2], 32'h100);
    check("we0_read", data_ram, 32'h100);

    // An unaligned address rounds down to its word, and high address bits alias.
    apply(1'b1, 32'h6, 32'hA5, "unal");
    check("unal_ram1", dut.RAM[1], 32'hA5);
    apply(1'b1, 32'h80, 32'h77, "alias");
    check("alias_ram0", dut.RAM[0], 32'h77);
    apply(1'b0, 32'h0, 32'h0, "alias_rd");
    check("alias_rd0", data_ram, 32'h77);

    // Read during write: the old word shows before the edge and the new word after it.
    signal_we    = 1'b1;
    addres_write = 32'h4;
    data_write   = 32'h55;
    #1;
    check("rdw_pre", data_ram, 32'hA5);
    @(posedge clk);
    model[1] = 32'h55;
    #1;
    check("rdw_post", data_ram, 32'h55);
    signal_we = 1'b0;

    // Random traffic checked against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rd;
      logic         rw;
      ra = $urandom();
      rd = $urandom();
      rw = ($urandom_range(0, 2) != 0);
      apply(rw, ra, rd, $sformatf("rnd%0d", n));
    end
    check_all("rnd_end");

    // A mid-cycle reset clears RAM at once, and a write attempted during reset is ignored.
    apply(1'b1, 32'hC, 32'hCAFE_0001, "pre_rst");
    #3 rst_n = 1'b0;
    clear_model();
    #1;
    check_all("midrst");
    check("midrst_read", data_ram, 32'h0);
    signal_we    = 1'b1;
    addres_write = 32'hC;
    data_write   = 32'h1234_5678;
    @(posedge clk);
    #1;
    check("rstwr_ram3", dut.RAM[3], 32'h0);
    check("rstwr_read", data_ram, 32'h0);
    check_all("rstwr");
    signal_we = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b1, 32'h10, 32'h0BAD_F00D, "post_rst");
    check("post_rst_ram4", dut.RAM[4], 32'h0BAD_F00D);
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
